// File: rtl/toggle_pulse_rx.sv
// Toggle-event receiver: synchronises a toggling level into the clk domain,
// emits a one-cycle pulse per transition and keeps a saturating count of
// pending events that a consumer pops through a valid/ready handshake.
module toggle_pulse_rx #(
   parameter int unsigned SYNC_STAGES = 2,  // legal range 2..4
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             t_in,
   output logic             pulse,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] evt_count,
   output logic             overflow,
   input  logic             clr_ovf
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_n;
   logic                   prev_q;
   logic                   pulse_q;
   logic [CNT_W-1:0]       count_q;
   logic                   ovf_q;
   logic                   inc;
   logic                   pop;
   logic                   at_max;
   logic                   ovf_set;

   assign sync_n = sync_q[SYNC_STAGES-1];

   // Synchroniser and edge register run through reset so a static level
   // is already settled when reset releases and never reads as an event.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
      prev_q <= sync_n;
   end

   // Registered one-cycle strobe per synchronised transition.
   always_ff @(posedge clk) begin
      pulse_q <= (sync_n ^ prev_q) & ~rst;
   end

   assign inc     = pulse_q;
   assign pop     = evt_valid & evt_ready;
   assign at_max  = (count_q == CntMax);
   // Simultaneous inc and pop nets to zero, even when saturated.
   assign ovf_set = inc & ~pop & at_max;

   // Pending-event counter and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (inc && !pop) begin
            if (!at_max) begin
               count_q <= count_q + 1'b1;
            end
         end else if (!inc && pop) begin
            count_q <= count_q - 1'b1;
         end
         // Set wins over clear in the same cycle.
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (clr_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign pulse     = pulse_q;
   assign evt_count = count_q;
   assign evt_valid = (count_q != '0);
   assign overflow  = ovf_q;

endmodule
